// File: rtl/sdes_round_sequencer.sv
// S-DES round sequencer: one shared FK stage carries a byte through IP, two Feistel
// rounds and IP^-1, with valid/ready flow control on both the input and the output side.
module sdes_round_sequencer #(
    parameter logic [9:0] KEY_RESET = 10'b0000000000,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [9:0]       key_in,
    output logic             key_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [1:0] {IDLE, RND1, RND2, DONE} state_t;

    // Each S-box is indexed by {row, col}: row = outer bits, col = inner bits of the nibble.
    localparam logic [1:0] S0_TBL [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                           2'd3, 2'd2, 2'd1, 2'd0,
                                           2'd0, 2'd2, 2'd1, 2'd3,
                                           2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] S1_TBL [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                           2'd2, 2'd0, 2'd1, 2'd3,
                                           2'd3, 2'd0, 2'd1, 2'd0,
                                           2'd2, 2'd1, 2'd0, 2'd3};

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    // FK: left nibble XOR P4(S-boxes(E/P(right) ^ subkey)); right nibble passes through.
    function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] sk);
        logic [7:0] t;
        logic [3:0] s;
        t = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ sk;
        s = {S0_TBL[{t[7], t[4], t[6], t[5]}], S1_TBL[{t[3], t[0], t[2], t[1]}]};
        return {d[7:4] ^ {s[2], s[0], s[1], s[3]}, d[3:0]};
    endfunction

    state_t     state;
    logic [9:0] key_reg;
    logic [7:0] data_reg;
    logic       mode_reg;

    logic [9:0] key_p10;
    logic [9:0] ks1;
    logic [9:0] ks3;
    logic [7:0] k1;
    logic [7:0] k2;

    // Both subkeys derive from the stored key only, so key_in changes never reach a byte in flight.
    assign key_p10 = p10(key_reg);
    assign ks1     = {key_p10[8:5], key_p10[9], key_p10[3:0], key_p10[4]};
    assign ks3     = {ks1[7:5], ks1[9:8], ks1[2:0], ks1[4:3]};
    assign k1      = p8(ks1);
    assign k2      = p8(ks3);

    logic       use_k1;
    logic [7:0] fk_key;
    logic [7:0] fk_out;

    // Single FK datapath; the round state and the latched mode pick its subkey.
    assign use_k1 = (state == RND1) ? ~mode_reg : mode_reg;
    assign fk_key = use_k1 ? k1 : k2;
    assign fk_out = fk(data_reg, fk_key);

    // NOTE: every register here uses <= so all of them update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_reg   <= KEY_RESET;
            data_reg  <= '0;
            mode_reg  <= 1'b0;
            out_data  <= '0;
            blk_count <= '0;
            out_valid <= 1'b0;
            key_err   <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            key_err <= key_load && (state != IDLE);
            case (state)
                IDLE: begin
                    if (key_load) key_reg <= key_in;
                    if (in_valid && in_ready) begin
                        data_reg <= ip(in_data);
                        mode_reg <= mode;
                        state    <= RND1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RND1: begin
                    data_reg <= {fk_out[3:0], fk_out[7:4]};
                    state    <= RND2;
                end
                RND2: begin
                    out_data  <= ip_inv(fk_out);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        blk_count <= blk_count + CNT_W'(1);
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_round_sequencer.sv
// Bench for sdes_round_sequencer: directed S-DES vectors, a scoreboard queue of expected
// result bytes drained by an independent output monitor, plus timing/control checks.
module tb_sdes_round_sequencer;

    localparam int         CNT_W = 2;
    localparam logic [9:0] KEY_A = 10'b1010000010;
    localparam logic [9:0] KEY_B = 10'b1111111111;

    logic             clk;
    logic             rst;
    logic             key_load;
    logic [9:0]       key_in;
    logic             key_err;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             busy;
    logic [CNT_W-1:0] blk_count;

    sdes_round_sequencer #(
        .KEY_RESET(10'b0000000000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_in   (key_in),
        .key_err  (key_err),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .blk_count(blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    int         last_acc = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte once in_ready is up; optionally queues its expected result.
    task automatic accept(input logic [7:0] d, input logic m, input logic kl,
                          input logic [9:0] k, input logic push, input logic [7:0] exp);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_wait_in_ready", in_ready, 1);
        key_load = kl;
        key_in   = k;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        if (push) exp_q.push_back(exp);
        tick();
        last_acc = cyc;
        in_valid = 1'b0;
        key_load = 1'b0;
        in_data  = ~d;
        mode     = ~m;
    endtask

    // Scoreboard monitor: every consumed result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_result_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("sb_out_data", out_data, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_key_err", key_err, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_out_data", out_data, 8'h00);
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);

        // 1: key load together with first byte; encrypt 0x97 -> 0x38, check latency
        accept(8'b10010111, 1'b0, 1'b1, KEY_A, 1'b1, 8'b00111000);
        check("t1_busy_rnd1", busy, 1);
        check("t1_in_ready_rnd1", in_ready, 0);
        check("t1_key_err_idle_load", key_err, 0);
        tick();
        check("t1_out_valid_e1", out_valid, 0);
        tick();
        check("t1_out_valid_e2", out_valid, 1);
        check("t1_out_data", out_data, 8'b00111000);
        tick();
        check("t1_blk_count", blk_count, 1);
        check("t1_out_valid_after", out_valid, 0);
        check("t1_in_ready_after", in_ready, 1);

        // 2: decrypt back
        accept(8'b00111000, 1'b1, 1'b0, '0, 1'b1, 8'b10010111);
        tick();
        tick();
        check("t2_out_data", out_data, 8'b10010111);
        tick();
        check("t2_blk_count", blk_count, 2);

        // 3: back-pressure in DONE for 5 cycles, input offered but ignored
        out_ready = 1'b0;
        accept(8'b10010111, 1'b0, 1'b0, '0, 1'b1, 8'b00111000);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            check("t3_hold_out_valid", out_valid, 1);
            check("t3_hold_out_data", out_data, 8'b00111000);
            check("t3_hold_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        check("t3_blk_count_held", blk_count, 2);
        out_ready = 1'b1;
        tick();
        check("t3_blk_count_release", blk_count, 3);
        tick();
        check("t3_blk_count_once", blk_count, 3);
        check("t3_out_valid_after", out_valid, 0);

        // 4: key_load during RND1 is rejected with a one-cycle key_err
        accept(8'b00111000, 1'b1, 1'b0, '0, 1'b1, 8'b10010111);
        key_load = 1'b1;
        key_in   = KEY_B;
        tick();
        key_load = 1'b0;
        check("t4_key_err_pulse", key_err, 1);
        tick();
        check("t4_key_err_clear", key_err, 0);
        check("t4_out_data_old_key", out_data, 8'b10010111);
        tick();
        check("t4_blk_count_wrap", blk_count, 0);
        accept(8'b10010111, 1'b0, 1'b0, '0, 1'b1, 8'b00111000);
        tick();
        tick();
        tick();
        check("t4_blk_count_next", blk_count, 1);

        // 5: reset during RND2 aborts the byte and restores the reset key (all zeros)
        accept(8'b10010111, 1'b0, 1'b0, '0, 1'b0, 8'h00);
        tick();
        rst = 1'b1;
        #2;
        check("t5_out_valid_in_rst", out_valid, 0);
        check("t5_busy_in_rst", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("t5_in_ready", in_ready, 1);
        check("t5_blk_count", blk_count, 0);
        check("t5_out_data", out_data, 8'h00);
        tick();
        tick();
        accept(8'h00, 1'b0, 1'b0, '0, 1'b1, 8'hF0);
        accept(8'hF0, 1'b1, 1'b0, '0, 1'b1, 8'h00);
        tick();
        tick();
        tick();
        check("t5_blk_count_after", blk_count, 2);

        // 6: fresh counter, five back-to-back bytes, wrap and 4-cycle spacing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        key_load = 1'b1;
        key_in   = KEY_A;
        tick();
        key_load = 1'b0;
        check("t6_blk_count_start", blk_count, 0);
        for (int i = 0; i < 5; i++) begin
            int prev;
            prev = last_acc;
            if (i % 2 == 0) accept(8'b10010111, 1'b0, 1'b0, '0, 1'b1, 8'b00111000);
            else            accept(8'b00111000, 1'b1, 1'b0, '0, 1'b1, 8'b10010111);
            if (i > 0) begin
                check("t6_spacing", last_acc - prev, 4);
                check("t6_blk_count", blk_count, i % 4);
            end
        end
        tick();
        tick();
        tick();
        check("t6_blk_count_final", blk_count, 1);

        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdes_round_sequencer.md
Name: sdes_round_sequencer

Overview:
- Multi-cycle S-DES engine controller. Time-shares one FK_operation instance across both Feistel rounds.
- Sequences the existing library functions: IP_Function, then FK with K1, then SWAP, then FK with K2, then IP_Inverse.
- Selects subkey order for encrypt or decrypt, and holds the 10-bit master key.
- Sits between a byte-stream producer and consumer using valid/ready handshakes on both sides.

Parameters:
- KEY_RESET, 10'b0000000000, value loaded into the key register on reset.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_load  input  1  when high in IDLE, captures key_in at the clock edge.
- key_in  input  10  S-DES master key, bit 9 = leftmost.
- key_err  output  1  one-cycle pulse: key_load was asserted while not IDLE and was ignored.
- in_valid  input  1  in_data and mode are valid.
- in_ready  output  1  block can accept a byte.
- in_data  input  8  plaintext or ciphertext byte, bit 7 = leftmost.
- mode  input  1  0 = encrypt (K1 then K2), 1 = decrypt (K2 then K1). Sampled with in_data.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  8  result byte.
- busy  output  1  high in any state other than IDLE.
- blk_count  output  CNT_W  number of results consumed (out_valid and out_ready), wraps modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous and active-high. It forces:
  - state to IDLE and key register to KEY_RESET;
  - data register, out_data and blk_count to 0;
  - out_valid, key_err and busy to 0;
  - in_ready to 1 once rst is released.
- Subkeys come from the stored key register through the existing P10/shift/P8 key-gen modules, combinationally. Subkeys never come directly from key_in.
- FSM states: IDLE, RND1, RND2, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid and in_ready: data_reg <= IP(in_data), mode_reg <= mode, go to RND1.
  - If key_load is also high in the same cycle, the key is captured first. The new key applies to this byte.
- RND1: data_reg <= SWAP(FK(data_reg, kA)), go to RND2. kA = K1 if mode_reg = 0, else K2.
- RND2: out_data <= IP_Inverse(FK(data_reg, kB)), out_valid <= 1, go to DONE. kB is the other subkey.
- DONE:
  - out_valid and out_data are held stable until out_ready is high.
  - On out_ready: out_valid <= 0, blk_count increments, go to IDLE.
  - in_ready stays 0; no bypass.
- Latency:
  - Accept edge E0. out_valid rises after edge E0+2.
  - Minimum spacing between accepted bytes is 4 cycles (out_ready tied high).
- in_ready is a function of state only. It does not depend on in_valid.
- key_load outside IDLE: the key register is unchanged and key_err pulses for exactly one cycle on each such edge.
- mode and key changes while busy do not affect the byte in flight.
- blk_count at all-ones wraps to 0 on the next consumed result.
- rst asserted mid-operation aborts the byte. No output is produced for it and the state after reset is as listed above.
- The FK_operation instance is single. Each round's operands are selected by a mux on the state.

Test Plan:
1. Reset, then key_load with key_in=10'b1010000010, then encrypt in_data=8'b10010111 -> out_data=8'b00111000. out_valid rises 2 edges after accept. blk_count=1.
2. Same key, mode=1, in_data=8'b00111000 -> out_data=8'b10010111.
3. Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid ignored. On release, blk_count increments once.
4. Pulse key_load with a new key during RND1 -> key_err single-cycle pulse. Current result is computed with the old key, and the next byte also uses the old key.
5. Assert rst during RND2 -> out_valid=0, busy=0, key reverts to KEY_RESET, no blk_count change. Next byte processes correctly.
6. CNT_W=2, stream 5 bytes back-to-back with out_ready=1 -> blk_count sequence 1,2,3,0,1 and accept spacing of 4 cycles.
